// File: rtl/regfile_dumper.sv
// -----------------------------------------------------------------------------
// regfile_dumper
//
// Sequential read-side master for the register file. A start pulse in IDLE
// launches a sweep over registers 0..NUM_REGS-1 through one read port. Each
// word takes READ (index presented), LATCH (registered read data arrives) and
// SEND (beat held on a valid/ready handshake until the sink takes it).
//
// Optional feature macro: CHECKSUM_EN
//   defined   : after the last register beat a CSUM state sends one extra beat
//               carrying the wrapping sum of all words (dump_csum=1,
//               dump_last=1, dump_index=NUM_REGS-1).
//   undefined : no checksum state or accumulator; dump_csum is tied to 0 and
//               the last register beat carries dump_last=1.
//
// Parameters
//   NUM_REGS  number of registers swept
//   ADDR_W    register index width (NUM_REGS <= 2**ADDR_W)
//   DATA_W    register data width
//
// Ports
//   clk          clock, all state on posedge
//   reset        synchronous active-high reset, aborts any sweep
//   start        one-cycle sweep request, honoured only in IDLE
//   busy         high from the cycle after start is accepted through done
//   done         one-cycle pulse after the final beat transfers
//   rf_readReg   index to the register file read port
//   rf_readData  read data, valid one cycle after rf_readReg is sampled
//   dump_data    streamed word
//   dump_index   register index of dump_data
//   dump_csum    beat carries the checksum
//   dump_last    final beat of the sweep
//   dump_valid   beat valid
//   dump_ready   sink accepts the beat
// -----------------------------------------------------------------------------
module regfile_dumper #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_readReg,
  input  logic [DATA_W-1:0] rf_readData,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_csum,
  output logic              dump_last,
  output logic              dump_valid,
  input  logic              dump_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_SEND,
`ifdef CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rf_readReg;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_dump_data;
  logic [ADDR_W-1:0] r_dump_index;
  logic              r_dump_last;
  logic              r_dump_valid;

  logic              w_xfer;
  logic              w_last_idx;

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  logic              r_dump_csum;

  // Checksum is a plain modular sum; overflow wraps silently.
  function automatic logic [DATA_W-1:0] f_wrap_add(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return a + b;
  endfunction
`endif

  assign w_xfer     = r_dump_valid & dump_ready;
  assign w_last_idx = (r_index == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_xfer) begin
          if (!w_last_idx) begin
            w_state_nxt = S_READ;
          end else begin
`ifdef CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef CHECKSUM_EN
      S_CSUM:  if (w_xfer) w_state_nxt = S_DONE;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rf_readReg <= '0;
      r_index      <= '0;
      r_dump_data  <= '0;
      r_dump_index <= '0;
      r_dump_last  <= 1'b0;
      r_dump_valid <= 1'b0;
`ifdef CHECKSUM_EN
      r_checksum   <= '0;
      r_dump_csum  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rf_readReg <= '0;
            r_index      <= '0;
            r_busy       <= 1'b1;
`ifdef CHECKSUM_EN
            r_checksum   <= '0;
`endif
          end
        end

        // S_READ: the file samples rf_readReg at the closing edge; nothing to do.

        S_LATCH: begin
          r_dump_data  <= rf_readData;
          r_dump_index <= r_index;
          r_dump_valid <= 1'b1;
`ifdef CHECKSUM_EN
          // The checksum beat is the true last beat, so register beats never are.
          r_dump_last  <= 1'b0;
          r_dump_csum  <= 1'b0;
          r_checksum   <= f_wrap_add(r_checksum, rf_readData);
`else
          r_dump_last  <= w_last_idx;
`endif
        end

        S_SEND: begin
          if (w_xfer) begin
            r_dump_valid <= 1'b0;
            if (!w_last_idx) begin
              r_index      <= r_index + ADDR_W'(1);
              r_rf_readReg <= r_index + ADDR_W'(1);
            end else begin
`ifdef CHECKSUM_EN
              // Present the checksum beat immediately in the CSUM cycle.
              r_dump_data  <= r_checksum;
              r_dump_index <= LAST_IDX;
              r_dump_csum  <= 1'b1;
              r_dump_last  <= 1'b1;
              r_dump_valid <= 1'b1;
`else
              r_done       <= 1'b1;
`endif
            end
          end
        end

`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_dump_valid <= 1'b0;
            r_done       <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end

        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rf_readReg = r_rf_readReg;
  assign dump_data  = r_dump_data;
  assign dump_index = r_dump_index;
  assign dump_last  = r_dump_last;
  assign dump_valid = r_dump_valid;
`ifdef CHECKSUM_EN
  assign dump_csum  = r_dump_csum;
`else
  assign dump_csum  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_dumper. Holds a behavioural register file (registered
// read, one-cycle latency) and a reference model that lists the beats a sweep
// must produce. Cycle 0 is the cycle in which start is high.
// -----------------------------------------------------------------------------
module tb_regfile_dumper;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int BUDGET   = 800;
`ifdef CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_readReg;
  logic [DATA_W-1:0] rf_readData;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic              dump_csum;
  logic              dump_last;
  logic              dump_valid;
  logic              dump_ready;

  regfile_dumper #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rf_readReg(rf_readReg), .rf_readData(rf_readData),
    .dump_data(dump_data), .dump_index(dump_index), .dump_csum(dump_csum),
    .dump_last(dump_last), .dump_valid(dump_valid), .dump_ready(dump_ready)
  );

  always #5 clk = ~clk;

  // Register file model: registered read port.
  logic [DATA_W-1:0] regs [NUM_REGS];
  always @(posedge clk) rf_readData <= regs[rf_readReg];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              csum;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Observations from the most recent sweep.
  int done_cnt, done_cyc, first_v, stab_err, stall_seen, tail_err;
  bit busy_c0, busy_c1, early_v, aborted;

  // Reference: every register in index order, then the checksum beat if enabled.
  function automatic void build_exp();
    logic [DATA_W-1:0] sum;
    beat_t b;
    exp_q.delete();
    sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sum    = sum + regs[i];
      b.data = regs[i];
      b.idx  = ADDR_W'(i);
      b.last = (i == NUM_REGS - 1) && !CSUM_ON;
      b.csum = 1'b0;
      exp_q.push_back(b);
    end
    if (CSUM_ON) begin
      b.data = sum;
      b.idx  = ADDR_W'(NUM_REGS - 1);
      b.last = 1'b1;
      b.csum = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  // Drives one sweep from a negedge and records what happens. No checking here.
  // mode 0: ready high, 1: stall beat stall_idx for stall_len cycles, 2: random.
  task automatic sweep(input int mode, input int stall_idx, input int stall_len,
                       input bit extra_starts, input int abort_idx);
    beat_t cur, prev_b;
    bit    prev_stall, seen_done, r;
    int    tail;
    got_q.delete();
    done_cnt = 0; done_cyc = -1; first_v = -1; stab_err = 0; stall_seen = 0;
    tail_err = 0; busy_c0 = 1'b0; busy_c1 = 1'b0; early_v = 1'b0; aborted = 1'b0;
    prev_stall = 1'b0; seen_done = 1'b0; tail = 0; prev_b = '0;
    for (int c = 0; c < BUDGET; c++) begin
      cur = '{dump_data, dump_index, dump_last, dump_csum};
      if (prev_stall && (cur !== prev_b || dump_valid !== 1'b1)) stab_err++;
      if (c == 0) busy_c0 = busy;
      if (c == 1) busy_c1 = busy;
      if (dump_valid === 1'b1 && c < 3) early_v = 1'b1;
      if (dump_valid === 1'b1 && first_v < 0) first_v = c;
      if (seen_done && (busy !== 1'b0 || dump_valid !== 1'b0)) tail_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (abort_idx >= 0 && dump_valid === 1'b1 && dump_index == ADDR_W'(abort_idx)) begin
        reset = 1'b1; start = 1'b0; dump_ready = 1'b0; aborted = 1'b1;
        return;
      end
      case (mode)
        1: begin
          if (dump_valid === 1'b1 && dump_index == ADDR_W'(stall_idx) &&
              dump_csum === 1'b0 && stall_seen < stall_len) begin
            r = 1'b0; stall_seen++;
          end else begin
            r = 1'b1;
          end
        end
        2:       r = ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      dump_ready = r;
      if (dump_valid === 1'b1 && r) got_q.push_back(cur);
      prev_stall = (dump_valid === 1'b1) && !r;
      prev_b     = cur;
      start = (c == 0) || (extra_starts && (c == 2 || c == 50 || done === 1'b1));
      if (done === 1'b1) seen_done = 1'b1;
      if (seen_done) begin
        tail++;
        if (tail > 8) begin
          start = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, rf_readReg, dump_csum, dump_last, dump_valid} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b rd=%0d csum=%b last=%b valid=%b, want all 0",
               busy, done, rf_readReg, dump_csum, dump_last, dump_valid);
    end
    total++;
    if ({dump_data, dump_index} !== '0) begin
      bad++;
      $display("FAIL reset_data: got data=%h index=%0d, want 0", dump_data, dump_index);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pattern_sweep();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = i * 32'h01010101;
    build_exp();
    dump_ready = 1'b1;
    repeat (3) @(negedge clk);   // ready high well before start
    sweep(0, -1, 0, 1'b0, -1);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL pat_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL pat_beat%0d: got d=%h i=%0d l=%b c=%b, want d=%h i=%0d l=%b c=%b", i,
                 got_q[i].data, got_q[i].idx, got_q[i].last, got_q[i].csum,
                 exp_q[i].data, exp_q[i].idx, exp_q[i].last, exp_q[i].csum);
      end
    end
    total++;
    if (first_v != 3) begin bad++; $display("FAIL pat_first_valid: got cycle %0d, want 3", first_v); end
    total++;
    if (early_v) begin bad++; $display("FAIL pat_early_valid: got valid before cycle 3, want none"); end
    total++;
    if (done_cyc != 3 * NUM_REGS + 1 + int'(CSUM_ON)) begin
      bad++; $display("FAIL pat_done_cycle: got %0d, want %0d", done_cyc, 3 * NUM_REGS + 1 + int'(CSUM_ON));
    end
    total++;
    if (busy_c0 !== 1'b0 || busy_c1 !== 1'b1) begin
      bad++; $display("FAIL pat_busy: got c0=%b c1=%b, want c0=0 c1=1", busy_c0, busy_c1);
    end
    total++;
    if (done_cnt != 1 || tail_err != 0) begin
      bad++; $display("FAIL pat_done_once: got done_cnt=%0d tail_err=%0d, want 1 and 0", done_cnt, tail_err);
    end
    total++;
    if (rf_readReg !== ADDR_W'(NUM_REGS - 1)) begin
      bad++; $display("FAIL pat_idle_rdreg: got %0d, want %0d", rf_readReg, NUM_REGS - 1);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    build_exp();
    sweep(1, 7, 5, 1'b0, -1);
    total++;
    if (stall_seen != 5 || stab_err != 0) begin
      bad++; $display("FAIL stall_hold: got stall_cycles=%0d unstable=%0d, want 5 and 0", stall_seen, stab_err);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL stall_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL stall_beat%0d: got d=%h i=%0d, want d=%h i=%0d", i,
                 got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
    total++;
    if (done_cyc != 3 * NUM_REGS + 1 + int'(CSUM_ON) + 5) begin
      bad++; $display("FAIL stall_done_cycle: got %0d, want %0d", done_cyc, 3 * NUM_REGS + 6 + int'(CSUM_ON));
    end
  endtask

  task automatic test_ignored_starts();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    build_exp();
    sweep(0, -1, 0, 1'b1, -1);
    total++;
    if (done_cnt != 1 || tail_err != 0) begin
      bad++; $display("FAIL start_ignored: got done_cnt=%0d tail_err=%0d, want 1 and 0", done_cnt, tail_err);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL start_beats: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL start_beat%0d: got d=%h i=%0d, want d=%h i=%0d", i,
                 got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_abort();
    int dn;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    build_exp();
    sweep(0, -1, 0, 1'b0, 12);
    total++;
    if (!aborted) begin bad++; $display("FAIL abort_reach: got no SEND at index 12, want one"); end
    @(negedge clk);
    total++;
    if ({busy, done, rf_readReg, dump_data, dump_index, dump_csum, dump_last, dump_valid} !== '0) begin
      bad++;
      $display("FAIL abort_zero: got busy=%b done=%b rd=%0d d=%h i=%0d v=%b, want all 0",
               busy, done, rf_readReg, dump_data, dump_index, dump_valid);
    end
    reset = 1'b0; dump_ready = 1'b1; dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || dump_valid !== 1'b0 || busy !== 1'b0) dn++;
    end
    total++;
    if (dn != 0) begin bad++; $display("FAIL abort_idle: got %0d active cycles after reset, want 0", dn); end
    sweep(0, -1, 0, 1'b0, -1);
    total++;
    if (got_q.size() != exp_q.size() || done_cnt != 1) begin
      bad++; $display("FAIL restart_count: got %0d beats done=%0d, want %0d and 1", got_q.size(), done_cnt, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL restart_beat%0d: got d=%h i=%0d, want d=%h i=%0d", i,
                 got_q[i].data, got_q[i].idx, exp_q[i].data, exp_q[i].idx);
      end
    end
  endtask

  task automatic test_deadbeef();
    logic [DATA_W-1:0] want;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    regs[NUM_REGS - 1] = 32'hDEADBEEF;
    want = 32'hDEADBEEF;
    sweep(0, -1, 0, 1'b0, -1);
    total++;
    if (got_q.size() != NUM_REGS + int'(CSUM_ON)) begin
      bad++; $display("FAIL dead_count: got %0d beats, want %0d", got_q.size(), NUM_REGS + int'(CSUM_ON));
    end else begin
      total++;
      if (got_q[NUM_REGS - 1].data !== want || got_q[NUM_REGS - 1].last !== !CSUM_ON) begin
        bad++; $display("FAIL dead_final: got d=%h last=%b, want d=%h last=%b",
                        got_q[NUM_REGS - 1].data, got_q[NUM_REGS - 1].last, want, !CSUM_ON);
      end
      if (CSUM_ON) begin
        total++;
        if (got_q[NUM_REGS].data !== want || got_q[NUM_REGS].csum !== 1'b1) begin
          bad++; $display("FAIL dead_csum: got d=%h c=%b, want d=%h c=1",
                          got_q[NUM_REGS].data, got_q[NUM_REGS].csum, want);
        end
      end
    end
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
    build_exp();
    sweep(2, -1, 0, 1'b0, -1);
    total++;
    if (stab_err != 0 || done_cnt != 1) begin
      bad++; $display("FAIL rand_hold: got unstable=%0d done_cnt=%0d, want 0 and 1", stab_err, done_cnt);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_beat%0d: got d=%h i=%0d l=%b, want d=%h i=%0d l=%b", i,
                 got_q[i].data, got_q[i].idx, got_q[i].last,
                 exp_q[i].data, exp_q[i].idx, exp_q[i].last);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    @(negedge clk);
    test_reset();
    test_pattern_sweep();
    test_stall();
    test_ignored_starts();
    test_abort();
    test_deadbeef();
    test_random_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
